// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the sequence-detector hit window counter.
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a timer that counts 0..win_len-1 (never narrower than one bit).
    function automatic int unsigned win_cnt_w(input int unsigned win_len);
        return (win_len <= 2) ? 1 : $clog2(win_len);
    endfunction

    // Largest value representable in w bits (w <= 16).
    function automatic logic [15:0] sat_max(input int unsigned w);
        return 16'((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
// count_next/ovf_next expose the value the counter would take with this
// cycle's inc applied, ignoring clear, so a window's final tally is visible
// on the same cycle it is cleared.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic [CNT_W-1:0] count_next,
    output logic             ovf_next
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    // Saturating increment; an increment attempted at MAX sets ovf.
    always_comb begin
        count_next = count_q;
        ovf_next   = ovf_q;
        if (inc) begin
            if (count_q == MAX) begin
                ovf_next = 1'b1;
            end else begin
                count_next = count_q + CNT_W'(1);
            end
        end
    end

    // Counter state; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_next;
            ovf_q   <= ovf_next;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/seq_hit_window_counter.sv
// Counts detector hits over fixed WIN_LEN-cycle windows and publishes each
// window's saturating count on a valid/ready interface. A result that cannot
// be stored because the previous one is still unconsumed is dropped and
// flagged with a one-cycle drop pulse.
module seq_hit_window_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned WIN_LEN = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hit,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_ovf,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             drop
);

    localparam int unsigned          TIMER_W = win_cnt_w(WIN_LEN);
    localparam logic [TIMER_W-1:0]   LAST    = TIMER_W'(WIN_LEN - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               acc_clear, acc_inc, win_end;
    logic [CNT_W-1:0]   acc_count, acc_final;
    logic               acc_ovf, acc_ovf_final;

    logic [CNT_W-1:0]   data_q;
    logic               ovf_q, valid_q, valid_d, drop_q, drop_d, load;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (acc_clear),
        .inc        (acc_inc),
        .count      (acc_count),
        .ovf        (acc_ovf),
        .count_next (acc_final),
        .ovf_next   (acc_ovf_final)
    );

    // Window FSM and timer. The IDLE cycle that sees en high is window cycle 0,
    // so the timer leaves IDLE already at 1.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        acc_clear = 1'b0;
        acc_inc   = 1'b0;
        win_end   = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (en) begin
                    state_d = RUN;
                    acc_inc = hit;
                    timer_d = TIMER_W'(1);
                end
            end
            RUN: begin
                if (!en) begin
                    // Partial window is discarded; any pending result is kept.
                    state_d   = IDLE;
                    timer_d   = '0;
                    acc_clear = 1'b1;
                end else begin
                    acc_inc = hit;
                    if (timer_q == LAST) begin
                        win_end   = 1'b1;
                        timer_d   = '0;
                        acc_clear = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result register control: the oldest unconsumed result wins.
    always_comb begin
        load    = win_end && (!valid_q || cnt_ready);
        drop_d  = win_end && valid_q && !cnt_ready;
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && cnt_ready) begin
            valid_d = 1'b0;
        end
    end

    // FSM state and timer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Output result registers and drop pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            if (load) begin
                data_q <= acc_final;
                ovf_q  <= acc_ovf_final;
            end
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign cnt_data  = data_q;
    assign cnt_ovf   = ovf_q;
    assign cnt_valid = valid_q;
    assign drop      = drop_q;

    // Registered accumulator outputs are only needed through count_next/ovf_next.
    logic unused_acc;
    assign unused_acc = ^{acc_count, acc_ovf};

endmodule

// File: tb/tb_seq_hit_window_counter.sv
// Directed bench for seq_hit_window_counter: two instances (8-bit and 2-bit
// counts, 8-cycle windows) share one stimulus stream; a cycle model predicts
// every output, expectations are queued per step and popped after the edge.
module tb_seq_hit_window_counter;

    localparam int WIN = 8;

    logic       clk;
    logic       rst_n, en, hit, cnt_ready;
    logic [7:0] d8_data;
    logic       d8_ovf, d8_valid, d8_drop;
    logic [1:0] d2_data;
    logic       d2_ovf, d2_valid, d2_drop;

    seq_hit_window_counter #(.WIN_LEN(8), .CNT_W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hit       (hit),
        .cnt_data  (d8_data),
        .cnt_ovf   (d8_ovf),
        .cnt_valid (d8_valid),
        .cnt_ready (cnt_ready),
        .drop      (d8_drop)
    );

    seq_hit_window_counter #(.WIN_LEN(8), .CNT_W(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hit       (hit),
        .cnt_data  (d2_data),
        .cnt_ovf   (d2_ovf),
        .cnt_valid (d2_valid),
        .cnt_ready (cnt_ready),
        .drop      (d2_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        ovf;
        logic        drop;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state, index 0 = 8-bit instance, 1 = 2-bit instance.
    int m_pos[2], m_hits[2], m_valid[2], m_data[2], m_ovf[2], m_drop[2];
    int m_max[2] = '{255, 3};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    function automatic void model_edge(input int i);
        int total;
        if (!rst_n) begin
            m_pos[i] = 0; m_hits[i] = 0; m_valid[i] = 0;
            m_data[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
            return;
        end
        m_drop[i] = 0;
        if (m_valid[i] != 0 && cnt_ready) m_valid[i] = 0;
        if (en) begin
            total = m_hits[i] + (hit ? 1 : 0);
            if (m_pos[i] == WIN - 1) begin
                if (m_valid[i] == 0) begin
                    m_valid[i] = 1;
                    m_data[i]  = (total > m_max[i]) ? m_max[i] : total;
                    m_ovf[i]   = (total > m_max[i]) ? 1 : 0;
                end else begin
                    m_drop[i] = 1;
                end
                m_pos[i]  = 0;
                m_hits[i] = 0;
            end else begin
                m_pos[i]++;
                m_hits[i] = total;
            end
        end else begin
            m_pos[i]  = 0;
            m_hits[i] = 0;
        end
    endfunction

    task automatic step(input logic r, input logic e, input logic h, input logic rd);
        exp_t x;
        rst_n = r; en = e; hit = h; cnt_ready = rd;
        for (int i = 0; i < 2; i++) begin
            model_edge(i);
            x.valid = (m_valid[i] != 0);
            x.data  = 16'(m_data[i]);
            x.ovf   = (m_ovf[i] != 0);
            x.drop  = (m_drop[i] != 0);
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk("valid8", {15'b0, d8_valid}, {15'b0, x.valid});
        chk("data8",  16'(d8_data),      x.data);
        chk("ovf8",   {15'b0, d8_ovf},   {15'b0, x.ovf});
        chk("drop8",  {15'b0, d8_drop},  {15'b0, x.drop});
        x = exp_q.pop_front();
        chk("valid2", {15'b0, d2_valid}, {15'b0, x.valid});
        chk("data2",  16'(d2_data),      x.data);
        chk("ovf2",   {15'b0, d2_ovf},   {15'b0, x.ovf});
        chk("drop2",  {15'b0, d2_drop},  {15'b0, x.drop});
    endtask

    task automatic window(input logic [7:0] hits, input logic [7:0] rdy);
        for (int c = 0; c < WIN; c++) step(1'b1, 1'b1, hits[c], rdy[c]);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; hit = 1'b0; cnt_ready = 1'b0;

        // Reset with hit toggling.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", {15'b0, d8_valid}, 16'd0);

        // Hits on cycles 1, 3, 7.
        window(8'b1000_1010, 8'hFF);
        chk("w1_valid", {15'b0, d8_valid}, 16'd1);
        chk("w1_data",  16'(d8_data),      16'd3);

        // All-hit window saturates the 2-bit count, then an empty window.
        window(8'hFF, 8'hFF);
        chk("sat_data2", 16'(d2_data),    16'd3);
        chk("sat_ovf2",  {15'b0, d2_ovf}, 16'd1);
        chk("sat_data8", 16'(d8_data),    16'd8);
        window(8'h00, 8'hFF);
        chk("zero_ovf2", {15'b0, d2_ovf}, 16'd0);

        // Stalled consumer: 2 hits held, 4-hit window dropped.
        window(8'b0001_0100, 8'h01);
        window(8'h0F, 8'h00);
        chk("stall_drop", {15'b0, d8_drop}, 16'd1);
        chk("stall_data", 16'(d8_data),     16'd2);
        window(8'b0111_1100, 8'h01);
        chk("third_data", 16'(d8_data), 16'd5);

        // Handshake on the window-end edge: new result loads, no drop.
        window(8'b0000_0001, 8'h80);
        chk("hs_valid", {15'b0, d8_valid}, 16'd1);
        chk("hs_data",  16'(d8_data),      16'd1);
        chk("hs_drop",  {15'b0, d8_drop},  16'd0);

        // Partial window abandoned after 3 hits; hits while idle ignored.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("abort_valid", {15'b0, d8_valid}, 16'd0);

        window(8'b0010_0000, 8'h00);
        chk("reen_data", 16'(d8_data), 16'd1);

        // Reset mid-window with a result pending.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_rst_valid", {15'b0, d8_valid}, 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
